// File: rtl/snake_defs_pkg.sv
// Shared direction encoding for the snake datapath: the pacer commits a
// direction, the head-update logic consumes it.
package snake_defs;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam int unsigned QUEUE_DEPTH = 2;
  localparam logic [7:0]  OVERRUN_MAX = 8'hFF;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_step_pacer_key_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// rising-edge detector so each press yields a single one-cycle request.
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise the raw level and remember last cycle's synchronised value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its input from
      // before the edge; blocking here would collapse the chain into one stage.
      r_meta <= i_key;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/snake_step_pacer.sv
// Step pacer: length-dependent tick generator, pending/overrun tracking,
// go pulse generation and a 2-deep turn queue committed on each go.
module snake_step_pacer
  import snake_defs::*;
#(
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000,
  parameter int unsigned STEP_DEC    = 1_000_000,
  parameter int unsigned INIT_LEN    = 4,
  parameter int          PERIOD_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        pause,
  input  logic        waiting,
  input  logic [10:0] length,
  output logic        go,
  output logic [1:0]  dir,
  output logic [7:0]  overrun
);

  // ---------------------------------------------------------------- period
  logic [31:0]         w_len32;
  logic [31:0]         w_dec;
  logic [31:0]         w_period;
  logic [PERIOD_W-1:0] w_reload;

  assign w_len32  = 32'(length);
  assign w_dec    = (w_len32 > INIT_LEN) ? (w_len32 - INIT_LEN) * STEP_DEC : 32'd0;
  assign w_period = (w_dec >= BASE_PERIOD - MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD - w_dec;
  assign w_reload = PERIOD_W'(w_period - 32'd1);

  // --------------------------------------------------------------- counter
  logic [PERIOD_W-1:0] r_cnt;
  logic                w_tick;

  assign w_tick = !pause && (r_cnt == '0);

  // Count down while running; reload from the current period on expiry so a
  // length change only takes effect at the next reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= PERIOD_W'(BASE_PERIOD - 32'd1);
    end else if (!pause) begin
      if (r_cnt == '0) r_cnt <= w_reload;
      else             r_cnt <= r_cnt - PERIOD_W'(1);
    end
  end

  // ----------------------------------------------------- pending / go logic
  logic       r_pending;
  logic       r_go;
  logic [7:0] r_overrun;
  logic       w_fire;

  assign w_fire = (r_pending | w_tick) & waiting;

  // Hold a tick until the controller waits; count ticks that land on an
  // unconsumed pending tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
      r_go      <= 1'b0;
      r_overrun <= 8'd0;
    end else begin
      r_go <= w_fire;
      if (w_fire)      r_pending <= 1'b0;
      else if (w_tick) r_pending <= 1'b1;
      if (w_tick && r_pending && !w_fire && r_overrun != OVERRUN_MAX)
        r_overrun <= r_overrun + 8'd1;
    end
  end

  // ------------------------------------------------------------------ keys
  logic w_rise_up, w_rise_down, w_rise_left, w_rise_right;

  key_edge_sync u_sync_up    (.clk(clk), .rst(rst), .i_key(key_up),    .o_rise(w_rise_up));
  key_edge_sync u_sync_down  (.clk(clk), .rst(rst), .i_key(key_down),  .o_rise(w_rise_down));
  key_edge_sync u_sync_left  (.clk(clk), .rst(rst), .i_key(key_left),  .o_rise(w_rise_left));
  key_edge_sync u_sync_right (.clk(clk), .rst(rst), .i_key(key_right), .o_rise(w_rise_right));

  logic w_req_valid;
  dir_t w_req_dir;

  // Pick one request per cycle: up > down > left > right.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_req_valid = 1'b1;
    w_req_dir   = DIR_UP;
    if      (w_rise_up)    w_req_dir = DIR_UP;
    else if (w_rise_down)  w_req_dir = DIR_DOWN;
    else if (w_rise_left)  w_req_dir = DIR_LEFT;
    else if (w_rise_right) w_req_dir = DIR_RIGHT;
    else                   w_req_valid = 1'b0;
  end

  // ----------------------------------------------------- queue and commit
  dir_t       r_q0;   // head
  dir_t       r_q1;   // second entry
  logic [1:0] r_qcnt;
  dir_t       r_dir;

  dir_t       w_q0_n, w_q1_n, w_dir_n, w_ref_dir;
  logic [1:0] w_qcnt_n;
  logic       w_pop, w_accept;

  assign w_pop = w_fire && (r_qcnt != 2'd0);

  // Apply the pop first, then validate the push against the post-pop tail
  // (or the committed direction when the queue drains).
  always_comb begin
    w_q0_n   = r_q0;
    w_q1_n   = r_q1;
    w_qcnt_n = r_qcnt;
    w_dir_n  = r_dir;
    if (w_pop) begin
      w_dir_n  = r_q0;
      w_q0_n   = r_q1;
      w_qcnt_n = r_qcnt - 2'd1;
    end
    if (w_qcnt_n == 2'd2)      w_ref_dir = w_q1_n;
    else if (w_qcnt_n == 2'd1) w_ref_dir = w_q0_n;
    else                       w_ref_dir = w_dir_n;
    w_accept = w_req_valid
            && (w_req_dir != w_ref_dir)
            && (w_req_dir != opposite(w_ref_dir))
            && (w_qcnt_n != 2'(QUEUE_DEPTH));
    if (w_accept) begin
      if (w_qcnt_n == 2'd0) w_q0_n = w_req_dir;
      else                  w_q1_n = w_req_dir;
      w_qcnt_n = w_qcnt_n + 2'd1;
    end
  end

  // Register queue state and the committed direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the two queue slots are reset along with the count; they are
      // only a few flops and a defined value keeps dir traceable after reset.
      r_q0   <= DIR_RIGHT;
      r_q1   <= DIR_RIGHT;
      r_qcnt <= 2'd0;
      r_dir  <= DIR_RIGHT;
    end else begin
      r_q0   <= w_q0_n;
      r_q1   <= w_q1_n;
      r_qcnt <= w_qcnt_n;
      r_dir  <= w_dir_n;
    end
  end

  assign go      = r_go;
  assign dir     = r_dir;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_snake_step_pacer.sv
// Directed bench for snake_step_pacer with short periods
// (BASE=20, MIN=8, STEP_DEC=2, INIT_LEN=4).
module tb_snake_step_pacer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic        pause = 1'b0;
  logic        waiting = 1'b1;
  logic [10:0] length = 11'd4;
  logic        go;
  logic [1:0]  dir;
  logic [7:0]  overrun;

  int n_checks = 0;
  int n_fail   = 0;

  snake_step_pacer #(
    .BASE_PERIOD(20), .MIN_PERIOD(8), .STEP_DEC(2), .INIT_LEN(4), .PERIOD_W(26)
  ) dut (
    .clk(clk), .rst(rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .pause(pause), .waiting(waiting), .length(length),
    .go(go), .dir(dir), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Count negedges until go is seen high; an expired budget is a failure.
  task automatic wait_go(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (go !== 1'b1 && n < 200);
    if (go !== 1'b1) check({tag, "_timeout"}, 32'(go), 32'd1);
  endtask

  task automatic interval(input string tag, input int exp);
    int n;
    wait_go(tag, n);
    check(tag, 32'(n), 32'(exp));
  endtask

  // 0 up, 1 down, 2 left, 3 right; the request is queued 3 edges after press.
  task automatic press(input int k);
    case (k)
      0: key_up    = 1'b1;
      1: key_down  = 1'b1;
      2: key_left  = 1'b1;
      default: key_right = 1'b1;
    endcase
    repeat (3) step();
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int gos;

    // Reset state
    repeat (3) step();
    check("rst_go", 32'(go), 32'd0);
    check("rst_dir", 32'(dir), 32'd3);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;

    // 1. base period, one-cycle go, dir unchanged
    interval("first_go", 20);
    step();
    check("go_width", 32'(go), 32'd0);
    wait_go("period_base", n);
    check("period_base", 32'(n + 1), 32'd20);
    interval("period_base2", 20);
    check("dir_idle", 32'(dir), 32'd3);

    // pause freezes the counter for 10 cycles
    pause = 1'b1;
    repeat (10) step();
    pause = 1'b0;
    wait_go("pause_stretch", n);
    check("pause_stretch", 32'(n + 10), 32'd30);

    // 2. period follows length, sampled at reload
    length = 11'd7;
    interval("len7_cur", 20);
    interval("len7_new", 14);
    length = 11'd10;           // d = 12 = BASE-MIN: clamp boundary
    interval("len10_cur", 14);
    interval("len10_clamp", 8);
    length = 11'd20;           // d = 32
    interval("len20_cur", 8);
    interval("len20_clamp", 8);
    length = 11'd4;
    interval("len4_cur", 8);
    interval("len4_restore", 20);

    // 3. two queued turns, third dropped when full
    press(0);
    press(2);
    press(1);
    wait_go("q_first", n);
    check("q_first_dir", 32'(dir), 32'd0);
    wait_go("q_second", n);
    check("q_second_dir", 32'(dir), 32'd2);
    wait_go("q_drop", n);
    check("q_full_drop", 32'(dir), 32'd2);

    // steer back to right: up, then right
    press(0);
    press(3);
    wait_go("steer1", n);
    check("steer_up", 32'(dir), 32'd0);
    wait_go("steer2", n);
    check("steer_right", 32'(dir), 32'd3);

    // 4. rejections: opposite of dir, same as dir, opposite of tail
    press(2);
    press(3);
    wait_go("rej1", n);
    check("reject_vs_dir", 32'(dir), 32'd3);
    press(0);
    press(1);
    wait_go("rej2", n);
    check("accept_up", 32'(dir), 32'd0);
    wait_go("rej3", n);
    check("reject_vs_tail", 32'(dir), 32'd0);

    // 5. waiting low for 45 cycles: pending held, one overrun
    waiting = 1'b0;
    gos = 0;
    repeat (45) begin
      step();
      if (go === 1'b1) gos++;
    end
    check("no_go_wait0", 32'(gos), 32'd0);
    check("overrun_one", 32'(overrun), 32'd1);
    waiting = 1'b1;
    step();
    check("go_after_wait", 32'(go), 32'd1);
    interval("resume_tick", 14);
    check("overrun_hold", 32'(overrun), 32'd1);

    // 6. reset mid-count with a full queue
    press(2);
    press(0);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("mid_rst_go", 32'(go), 32'd0);
    check("mid_rst_dir", 32'(dir), 32'd3);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    interval("post_rst_go", 20);
    check("post_rst_queue_empty", 32'(dir), 32'd3);
    interval("post_rst_period", 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
